irq_timer_ctrl: RTL and testbench
=================================

Name: irq_timer_ctrl

Overview:
- Machine-level interrupt source that drives the CSR unit's `interupt` input and consumes its trap-taken/mret handshake.
- Holds a 64-bit mtime/mtimecmp timer and a synchronized, latched external interrupt line.
- Memory-mapped on the data bus; the core programs it with ordinary loads/stores.
- Sits beside the CSR unit in the core top.

Parameters:
- PRESCALE, 1, clk cycles per mtime increment (must be ≥1).
- SYNC_STAGES, 2, flops on the external interrupt synchronizer.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- bus_addr  in  5  byte address within block (word-aligned)
- bus_wdata  in  32  write data
- bus_we  in  1  write strobe, one cycle
- bus_re  in  1  read strobe, one cycle
- bus_rdata  out  32  read data, valid the cycle after bus_re
- ext_irq_i  in  1  asynchronous external interrupt request
- irq_ack_i  in  1  CSR unit took the trap, one-cycle pulse
- irq_done_i  in  1  mret retired, one-cycle pulse
- interupt  out  1  interrupt request to the CSR unit
- irq_cause  out  32  mcause value for the current request

Behaviour:
- Register map:
  - 0x00 mtime_lo, 0x04 mtime_hi, 0x08 mtimecmp_lo, 0x0C mtimecmp_hi.
  - 0x10 ctrl: bit0 timer_en, bit1 ext_en.
  - 0x14 status: bit0 timer_pend (RO), bit1 ext_pend (write 1 to clear), bit3:2 FSM state (RO).
  - Unmapped reads return 0; unmapped writes are ignored.
- Reset values:
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, ctrl = 0, ext_pend = 0, prescale count = 0.
  - FSM = IDLE, interupt = 0, irq_cause = 0, bus_rdata = 0.
  - Reset mid-request drops interupt immediately (asynchronous).
- Timer:
  - Prescale counter counts 0..PRESCALE-1; mtime increments by 1 on the terminal count.
  - mtime is 64-bit and wraps FFFF_FFFF_FFFF_FFFF→0.
  - A bus write to a mtime half in the same cycle as an increment: the write wins for the written half, and that cycle's increment is lost.
  - timer_pend = timer_en && (mtime >= mtimecmp), unsigned and level-sensitive. It clears only by rewriting mtimecmp or by clearing timer_en.
- External interrupt:
  - ext_irq_i passes through SYNC_STAGES flops.
  - A rising edge of the synchronized signal sets ext_pend when ext_en = 1.
  - A W1C write and a rising edge in the same cycle: set wins.
- Request FSM, transitions evaluated at posedge:
  - IDLE: when (ext_pend && ext_en) || timer_pend, go to REQ and latch irq_cause. Priority is external > timer: cause 32'h8000_000B for external, 32'h8000_0007 for timer.
  - REQ: interupt = 1. On irq_ack_i go to SERVICE; interupt is low in the cycle after the ack.
  - SERVICE: interupt = 0. irq_cause holds. On irq_done_i go to IDLE.
  - IDLE spends at least one cycle before re-entering REQ, even if a source is still pending.
  - irq_ack_i outside REQ and irq_done_i outside SERVICE are ignored.
  - Clearing an enable while in REQ does not withdraw the request; the handler must clear the source.
- Reads: registered with 1-cycle latency. bus_re and bus_we in the same cycle: the write takes effect and rdata returns the old value.

Decomposition:
- Shared package irq_pkg holds:
  - typedef irq_state_e {IDLE, REQ, SERVICE}
  - register offset localparams (MTIME_LO..STATUS)
  - CAUSE_MTI and CAUSE_MEI constants
- One sub-module, irq_sync: a parameterized SYNC_STAGES synchronizer plus rising-edge detector, with asynchronous reset to 0.

Test Plan:
- Reset, then read 0x08/0x0C → rdata FFFF_FFFF twice. Read 0x00 → a small count. interupt = 0 throughout.
- PRESCALE = 1: write mtimecmp_lo = 10, mtimecmp_hi = 0, ctrl = 1 → interupt rises when mtime ≥ 10, irq_cause = 8000_0007. Pulse irq_ack → interupt low the next cycle. Write mtimecmp_lo = FFFF_FFFF, pulse irq_done → FSM IDLE, no re-request.
- ctrl = 3, mtimecmp = 0, pulse ext_irq_i for 3 cycles → after sync + 1 cycle the cause is 8000_000B (external beats timer). Ack, W1C status = 2, done → re-request with cause 8000_0007 after one IDLE cycle.
- Write mtime = FFFF_FFFF_FFFF_FFFE, mtimecmp = 0, ctrl = 0, wait 3 increments → mtime reads 0000_0000_0000_0001; no interrupt while timer_en = 0.
- Assert reset while in REQ → interupt = 0 and irq_cause = 0 asynchronously. After release: state IDLE, ctrl = 0.
- irq_ack_i in IDLE and irq_done_i in REQ → status[3:2] unchanged, interupt unchanged.

Source files
------------

// File: rtl/irq_pkg.sv
// irq_pkg: shared state encoding, register offsets and mcause values for the interrupt block
package irq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} irq_state_e;
    localparam logic [4:0] MTIME_LO    = 5'h00;
    localparam logic [4:0] MTIME_HI    = 5'h04;
    localparam logic [4:0] MTIMECMP_LO = 5'h08;
    localparam logic [4:0] MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] CTRL        = 5'h10;
    localparam logic [4:0] STATUS      = 5'h14;
    localparam logic [31:0] CAUSE_MTI  = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI  = 32'h8000_000B;
endpackage

// File: rtl/irq_sync.sv
// irq_sync: multi-flop synchronizer with a rising-edge pulse on the synchronized level
module irq_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic rise_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= STAGES'({sync_q, async_i});
            prev_q <= sync_q[STAGES-1];
        end
    end
    assign rise_o = sync_q[STAGES-1] && !prev_q;
endmodule

// File: rtl/irq_timer_ctrl.sv
// irq_timer_ctrl: memory-mapped mtime/mtimecmp timer and external interrupt source for the CSR unit
module irq_timer_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned PRESCALE    = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [31:0] bus_rdata,
    input  logic        ext_irq_i,
    input  logic        irq_ack_i,
    input  logic        irq_done_i,
    output logic        interupt,
    output logic [31:0] irq_cause
);
    logic [31:0] psc_q, psc_d;
    logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        ext_pend_q, ext_pend_d;
    irq_state_e  state_q, state_d;
    logic [31:0] cause_q, cause_d, rdata_q, rdata_d, rd_val;
    logic        tick, timer_pend, ext_req, ext_rise;
    irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .async_i(ext_irq_i),
        .rise_o (ext_rise)
    );
    assign tick       = psc_q == 32'(PRESCALE - 1);
    assign timer_pend = ctrl_q[0] && (mtime_q >= mtimecmp_q);
    assign ext_req    = ext_pend_q && ctrl_q[1];
    always_comb begin
        psc_d      = tick ? 32'd0 : psc_q + 32'd1;
        // a write to either half swallows that cycle's increment
        mtime_d    = (bus_we && bus_addr == MTIME_LO) ? {mtime_q[63:32], bus_wdata} :
                     (bus_we && bus_addr == MTIME_HI) ? {bus_wdata, mtime_q[31:0]} :
                     mtime_q + {63'd0, tick};
        mtimecmp_d = (bus_we && bus_addr == MTIMECMP_LO) ? {mtimecmp_q[63:32], bus_wdata} :
                     (bus_we && bus_addr == MTIMECMP_HI) ? {bus_wdata, mtimecmp_q[31:0]} :
                     mtimecmp_q;
        ctrl_d     = (bus_we && bus_addr == CTRL) ? bus_wdata[1:0] : ctrl_q;
        ext_pend_d = (ext_rise && ctrl_q[1]) ||
                     (ext_pend_q && !(bus_we && bus_addr == STATUS && bus_wdata[1]));
        rd_val     = bus_addr == MTIME_LO    ? mtime_q[31:0] :
                     bus_addr == MTIME_HI    ? mtime_q[63:32] :
                     bus_addr == MTIMECMP_LO ? mtimecmp_q[31:0] :
                     bus_addr == MTIMECMP_HI ? mtimecmp_q[63:32] :
                     bus_addr == CTRL        ? {30'd0, ctrl_q} :
                     bus_addr == STATUS      ? {28'd0, state_q, ext_pend_q, timer_pend} : 32'd0;
        rdata_d    = bus_re ? rd_val : rdata_q;
    end
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: if (ext_req || timer_pend) begin
                state_d = REQ;
                cause_d = ext_req ? CAUSE_MEI : CAUSE_MTI;
            end
            REQ:     if (irq_ack_i) state_d = SERVICE;
            SERVICE: if (irq_done_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc_q      <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            ctrl_q     <= '0;
            ext_pend_q <= 1'b0;
            state_q    <= IDLE;
            cause_q    <= '0;
            rdata_q    <= '0;
        end else begin
            psc_q      <= psc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            ext_pend_q <= ext_pend_d;
            state_q    <= state_d;
            cause_q    <= cause_d;
            rdata_q    <= rdata_d;
        end
    end
    assign interupt  = state_q == REQ;
    assign irq_cause = cause_q;
    assign bus_rdata = rdata_q;
endmodule

// File: tb/tb_irq_timer_ctrl.sv
// tb_irq_timer_ctrl: directed self-checking bench with a read-data scoreboard
module tb_irq_timer_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic        bus_we = 1'b0;
    logic        bus_re = 1'b0;
    logic [31:0] bus_rdata;
    logic        ext_irq_i = 1'b0;
    logic        irq_ack_i = 1'b0;
    logic        irq_done_i = 1'b0;
    logic        interupt;
    logic [31:0] irq_cause;
    int          total = 0;
    int          passed = 0;
    int          fails = 0;
    int          n;
    logic [31:0] exp_q[$];

    irq_timer_ctrl #(.PRESCALE(1), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_rdata (bus_rdata),
        .ext_irq_i (ext_irq_i),
        .irq_ack_i (irq_ack_i),
        .irq_done_i(irq_done_i),
        .interupt  (interupt),
        .irq_cause (irq_cause)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus_addr = a;
        bus_wdata = d;
        bus_we = 1'b1;
        tick();
        bus_we = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        bus_addr = a;
        bus_re = 1'b1;
        tick();
        bus_re = 1'b0;
        chk(tag, bus_rdata, exp_q.pop_front());
    endtask

    task automatic pulse_ack();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
    endtask

    task automatic pulse_done();
        irq_done_i = 1'b1;
        tick();
        irq_done_i = 1'b0;
    endtask

    task automatic wait_irq(output int cnt);
        cnt = 0;
        while (!interupt && cnt < 50) begin
            tick();
            cnt++;
        end
        chk("irq_rise_within_bound", interupt, 1);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_interupt", interupt, 0);
        chk("rst_cause", irq_cause, 0);
        chk("rst_rdata", bus_rdata, 0);
        reset = 1'b0;
        rd("cmp_lo_rst", 5'h08, 32'hFFFF_FFFF);
        rd("cmp_hi_rst", 5'h0C, 32'hFFFF_FFFF);
        rd("ctrl_rst", 5'h10, 32'h0);
        bus_addr = 5'h00;
        bus_re = 1'b1;
        tick();
        bus_re = 1'b0;
        chk("mtime_small", bus_rdata < 32'd32, 1);
        rd("unmapped_rd", 5'h18, 32'h0);
        chk("idle_no_irq", interupt, 0);

        // timer request: mtime restarted at 0, compare at 10
        wr(5'h00, 32'd0);
        wr(5'h08, 32'd10);
        wr(5'h0C, 32'd0);
        wr(5'h10, 32'd1);
        chk("timer_not_yet", interupt, 0);
        wait_irq(n);
        chk("timer_latency", n, 8);
        chk("timer_cause", irq_cause, 32'h8000_0007);
        rd("status_req", 5'h14, 32'h5);
        pulse_ack();
        chk("ack_drops_irq", interupt, 0);
        chk("service_cause_hold", irq_cause, 32'h8000_0007);
        rd("status_service", 5'h14, 32'h9);
        wr(5'h08, 32'hFFFF_FFFF);
        pulse_done();
        repeat (3) tick();
        chk("no_rerequest", interupt, 0);
        rd("status_idle", 5'h14, 32'h0);
        pulse_ack();
        rd("ack_in_idle_ignored", 5'h14, 32'h0);
        chk("ack_in_idle_irq", interupt, 0);

        // external beats timer when both are pending at the IDLE decision
        wr(5'h10, 32'd0);
        wr(5'h08, 32'd0);
        wr(5'h10, 32'd3);
        wait_irq(n);
        chk("timer_first_cause", irq_cause, 32'h8000_0007);
        pulse_ack();
        ext_irq_i = 1'b1;
        repeat (3) tick();
        ext_irq_i = 1'b0;
        repeat (3) tick();
        rd("status_both_pend", 5'h14, 32'hB);
        pulse_done();
        chk("idle_gap_1", interupt, 0);
        tick();
        chk("ext_req", interupt, 1);
        chk("ext_cause", irq_cause, 32'h8000_000B);
        pulse_ack();
        wr(5'h14, 32'h2);
        rd("w1c_cleared", 5'h14, 32'h9);
        pulse_done();
        chk("idle_gap_2", interupt, 0);
        tick();
        chk("timer_rereq", interupt, 1);
        chk("timer_rereq_cause", irq_cause, 32'h8000_0007);
        pulse_done();
        chk("done_in_req_irq", interupt, 1);
        rd("done_in_req_status", 5'h14, 32'h5);
        pulse_ack();
        wr(5'h10, 32'd0);
        pulse_done();
        repeat (2) tick();
        chk("disabled_idle", interupt, 0);

        // 64-bit wrap with timer disabled
        wr(5'h00, 32'hFFFF_FFFE);
        wr(5'h04, 32'hFFFF_FFFF);
        repeat (3) tick();
        rd("wrap_lo", 5'h00, 32'h1);
        rd("wrap_hi", 5'h04, 32'h0);
        chk("wrap_no_irq", interupt, 0);

        // asynchronous reset while requesting
        wr(5'h10, 32'd1);
        wait_irq(n);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_irq", interupt, 0);
        chk("async_rst_cause", irq_cause, 0);
        tick();
        reset = 1'b0;
        rd("post_rst_ctrl", 5'h10, 32'h0);
        rd("post_rst_status", 5'h14, 32'h0);
        chk("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
